// File: rtl/ram_port_scheduler.sv
// ---------------------------------------------------------------------------
// ram_port_scheduler
//
// Runs one accelerator job (FFT, FIR or IIR) over the shared RAM address
// line. It steps through IDLE -> LOAD -> RUN -> DONE and drives the enable
// and read/write pause inputs of the address-calculation top level, so only
// one address calculator owns the bus in any cycle. While in RUN it shares
// the bus between the read channel (RAM -> accelerator) and the write
// channel (accelerator -> RAM) with a burst-limited round robin. It also
// counts the words moved on each channel.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   start             one-cycle job start pulse, sampled only in IDLE
//   mode_sel[1:0]     job type taken with start: 01 FFT, 10 FIR, 11 IIR
//   abort             ends the current job without a done pulse
//   filesize[31:0]    job size in bytes taken with start (words = bytes/4)
//   rd_req, wr_req    accelerator can take a read word / has a result word
//   *_enable          address-calculator enables (selected one only)
//   *_read_pause,
//   *_write_pause     1 = hold that calculator
//   rd_grant,wr_grant channel owning the bus this cycle
//   rd_count,wr_count words moved on each channel
//   busy, done        job in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module ram_port_scheduler #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode_sel,
  input  logic             abort,
  input  logic [31:0]      filesize,
  input  logic             rd_req,
  input  logic             wr_req,
  output logic             fft_enable,
  output logic             fir_enable,
  output logic             iir_enable,
  output logic             fft_read_pause,
  output logic             fft_write_pause,
  output logic             fir_read_pause,
  output logic             fir_write_pause,
  output logic             iir_read_pause,
  output logic             iir_write_pause,
  output logic             rd_grant,
  output logic             wr_grant,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  state_t           state;
  state_t           next_state;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] words_q;
  logic [7:0]       burst_cnt;
  logic [7:0]       burst_next;
  logic             job_start;

  logic             rd_elig;
  logic             wr_elig;
  logic             keep_owner;
  logic             rd_gnt_next;
  logic             wr_gnt_next;

  logic [1:0]       mode_eff;
  logic [2:0]       sel_oh;
  logic [2:0]       en_next;
  logic [2:0]       rp_next;
  logic [2:0]       wp_next;
  logic             busy_next;
  logic             done_next;

  assign job_start = (state == S_IDLE) && (next_state == S_LOAD);

  // State register, with the job parameters, the word counters and the
  // burst length. The counters move in the same edge that registers the
  // grant, so a count already includes the word on the bus this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_q    <= 2'b00;
      words_q   <= '0;
      burst_cnt <= 8'd0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      state     <= next_state;
      burst_cnt <= burst_next;
      if (job_start) begin
        mode_q   <= mode_sel;
        words_q  <= CNT_W'(filesize >> 2);
        rd_count <= '0;
        wr_count <= '0;
      end else begin
        if (rd_gnt_next) rd_count <= rd_count + CNT_W'(1);
        if (wr_gnt_next) wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

  // Next-state logic. Abort overrides everything, so an abort in IDLE
  // also blocks a start in the same cycle. RUN exits once the final write
  // is already on the bus (wr_count has reached words).
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start && (mode_sel != 2'b00)) next_state = S_LOAD;
      S_LOAD: next_state = (words_q == '0) ? S_DONE : S_RUN;
      S_RUN:  if (wr_count == words_q) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  // Channel arbitration for the next cycle. A write is only eligible
  // while it stays behind the reads. When both channels compete, the
  // current owner keeps the bus until it has used BURST_LEN cycles in a
  // row. burst_cnt saturates at BURST_LEN, which is all the comparison
  // needs.
  always_comb begin
    rd_elig     = rd_req && (rd_count < words_q);
    wr_elig     = wr_req && (wr_count < rd_count);
    keep_owner  = burst_cnt < BURST_MAX;
    rd_gnt_next = 1'b0;
    wr_gnt_next = 1'b0;
    burst_next  = 8'd0;
    if ((state == S_RUN) && (next_state == S_RUN)) begin
      if (rd_elig && wr_elig) begin
        if (rd_grant) begin
          rd_gnt_next = keep_owner;
          wr_gnt_next = !keep_owner;
        end else if (wr_grant) begin
          wr_gnt_next = keep_owner;
          rd_gnt_next = !keep_owner;
        end else begin
          rd_gnt_next = 1'b1;
        end
      end else begin
        rd_gnt_next = rd_elig;
        wr_gnt_next = wr_elig;
      end
      if ((rd_gnt_next && rd_grant) || (wr_gnt_next && wr_grant))
        burst_next = keep_owner ? (burst_cnt + 8'd1) : burst_cnt;
      else if (rd_gnt_next || wr_gnt_next)
        burst_next = 8'd1;
    end
  end

  // Next-cycle output values. The mode is taken straight from mode_sel on
  // the IDLE -> LOAD edge because mode_q is only loaded at that edge. A
  // grant releases the matching pause of the selected calculator only.
  always_comb begin
    mode_eff = (state == S_IDLE) ? mode_sel : mode_q;
    case (mode_eff)
      2'b01:   sel_oh = 3'b001;
      2'b10:   sel_oh = 3'b010;
      2'b11:   sel_oh = 3'b100;
      default: sel_oh = 3'b000;
    endcase
    en_next   = (next_state != S_IDLE) ? sel_oh : 3'b000;
    rp_next   = ~(sel_oh & {3{rd_gnt_next}});
    wp_next   = ~(sel_oh & {3{wr_gnt_next}});
    busy_next = (next_state != S_IDLE);
    done_next = (next_state == S_DONE);
  end

  // Output registers. Every output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {iir_enable, fir_enable, fft_enable}                <= 3'b000;
      {iir_read_pause, fir_read_pause, fft_read_pause}    <= 3'b111;
      {iir_write_pause, fir_write_pause, fft_write_pause} <= 3'b111;
      rd_grant <= 1'b0;
      wr_grant <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      {iir_enable, fir_enable, fft_enable}                <= en_next;
      {iir_read_pause, fir_read_pause, fft_read_pause}    <= rp_next;
      {iir_write_pause, fir_write_pause, fft_write_pause} <= wp_next;
      rd_grant <= rd_gnt_next;
      wr_grant <= wr_gnt_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

endmodule

// File: tb/tb_ram_port_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ram_port_scheduler
//
// Scoreboard bench for ram_port_scheduler. Each stimulus cycle runs a
// job-level reference model. The model pushes the outputs it expects after
// the next rising edge into a queue. A separate monitor pops one entry at
// every falling edge and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_ram_port_scheduler;

  localparam int BURST_LEN = 4;
  localparam int CNT_W     = 32;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode_sel;
  logic        abort;
  logic [31:0] filesize;
  logic        rd_req;
  logic        wr_req;
  logic        fft_enable, fir_enable, iir_enable;
  logic        fft_read_pause, fft_write_pause;
  logic        fir_read_pause, fir_write_pause;
  logic        iir_read_pause, iir_write_pause;
  logic        rd_grant, wr_grant;
  logic [CNT_W-1:0] rd_count, wr_count;
  logic        busy, done;

  always #5 clk = ~clk;

  ram_port_scheduler #(.BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_sel(mode_sel),
    .abort(abort), .filesize(filesize), .rd_req(rd_req), .wr_req(wr_req),
    .fft_enable(fft_enable), .fir_enable(fir_enable), .iir_enable(iir_enable),
    .fft_read_pause(fft_read_pause), .fft_write_pause(fft_write_pause),
    .fir_read_pause(fir_read_pause), .fir_write_pause(fir_write_pause),
    .iir_read_pause(iir_read_pause), .iir_write_pause(iir_write_pause),
    .rd_grant(rd_grant), .wr_grant(wr_grant),
    .rd_count(rd_count), .wr_count(wr_count),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [2:0]  en;
    logic [2:0]  rp;
    logic [2:0]  wp;
    logic        rg;
    logic        wg;
    logic        bsy;
    logic        dn;
    logic [31:0] rc;
    logic [31:0] wc;
  } obs_t;

  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    done_seen = 0;
  int    cyc = 0;
  string cur_test = "init";

  // Reference model state: job phase, the job's parameters, and the
  // owner of the bus together with how long it has held it.
  int          m_phase = P_IDLE;
  int          m_mode = 0;
  int unsigned m_words = 0;
  int unsigned m_rc = 0;
  int unsigned m_wc = 0;
  int          m_owner = 0;
  int          m_run = 0;
  int          m_dones = 0;

  // Advance the model by one clock and return the outputs it expects
  // afterwards. Owner codes: 0 none, 1 read, 2 write.
  function automatic obs_t model_step(bit rstn, bit st, bit ab, logic [1:0] ms,
                                      logic [31:0] fs, bit rr, bit wr);
    obs_t        o;
    int          gr;
    bit          re;
    bit          we;
    int unsigned wc_before;
    logic [2:0]  sel;
    gr = 0;
    if (!rstn) begin
      m_phase = P_IDLE; m_mode = 0; m_words = 0; m_rc = 0; m_wc = 0;
      m_owner = 0; m_run = 0;
    end else begin
      wc_before = m_wc;
      if (m_phase == P_RUN && !ab && m_wc != m_words) begin
        re = rr && (m_rc < m_words);
        we = wr && (m_wc < m_rc);
        if (re && we) begin
          if (m_owner == 0)              gr = 1;
          else if (m_run < BURST_LEN)    gr = m_owner;
          else                           gr = 3 - m_owner;
        end else if (re) gr = 1;
        else if (we)     gr = 2;
      end
      if (gr == 0)            m_run = 0;
      else if (gr == m_owner) m_run++;
      else                    m_run = 1;
      m_owner = gr;
      if (gr == 1) m_rc++;
      if (gr == 2) m_wc++;
      if (ab) m_phase = P_IDLE;
      else begin
        case (m_phase)
          P_IDLE: if (st && ms != 2'b00) begin
            m_phase = P_LOAD; m_mode = int'(ms); m_words = fs >> 2;
            m_rc = 0; m_wc = 0;
          end
          P_LOAD: m_phase = (m_words == 0) ? P_DONE : P_RUN;
          P_RUN:  if (wc_before == m_words) m_phase = P_DONE;
          default: m_phase = P_IDLE;
        endcase
        if (m_phase == P_DONE) m_dones++;
      end
    end
    sel   = (m_phase != P_IDLE && m_mode != 0) ? (3'b001 << (m_mode - 1)) : 3'b000;
    o.en  = sel;
    o.rp  = (gr == 1) ? ~sel : 3'b111;
    o.wp  = (gr == 2) ? ~sel : 3'b111;
    o.rg  = (gr == 1);
    o.wg  = (gr == 2);
    o.bsy = (m_phase != P_IDLE);
    o.dn  = (m_phase == P_DONE);
    o.rc  = m_rc;
    o.wc  = m_wc;
    return o;
  endfunction

  // Drive one clock of inputs just after the falling edge, and queue the
  // response that the following rising edge should produce.
  task automatic applyStimulus(input bit rstn, input bit st, input bit ab,
                               input logic [1:0] ms, input logic [31:0] fs,
                               input bit rr, input bit wr);
    @(negedge clk);
    #1;
    rst_n = rstn; start = st; abort = ab; mode_sel = ms; filesize = fs;
    rd_req = rr; wr_req = wr;
    exp_q.push_back(model_step(rstn, st, ab, ms, fs, rr, wr));
  endtask

  task automatic checkOutput(input obs_t e);
    obs_t a;
    a.en  = {iir_enable, fir_enable, fft_enable};
    a.rp  = {iir_read_pause, fir_read_pause, fft_read_pause};
    a.wp  = {iir_write_pause, fir_write_pause, fft_write_pause};
    a.rg  = rd_grant;
    a.wg  = wr_grant;
    a.bsy = busy;
    a.dn  = done;
    a.rc  = rd_count;
    a.wc  = wr_count;
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got en=%b rp=%b wp=%b rg=%b wg=%b busy=%b done=%b rc=%0d wc=%0d, expected en=%b rp=%b wp=%b rg=%b wg=%b busy=%b done=%b rc=%0d wc=%0d",
               cur_test, cyc, a.en, a.rp, a.wp, a.rg, a.wg, a.bsy, a.dn, a.rc, a.wc,
               e.en, e.rp, e.wp, e.rg, e.wg, e.bsy, e.dn, e.rc, e.wc);
    end
  endtask

  // Monitor: compares whenever a queued expectation is due, and counts the
  // done pulses it sees.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      if (done === 1'b1) done_seen++;
    end
  end

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
  endtask

  // Run the current job to completion. The request pattern is one of:
  //   kind 0: random requests
  //   kind 1: reads first, then writes
  //   kind 2: both requests held high
  // With noisy set, the bench also scrambles start, mode, filesize and a
  // rare abort while the job runs.
  task automatic drain_job(input logic [1:0] ms, input logic [31:0] fs,
                           input int kind, input bit noisy);
    int          n;
    bit          rr, wr, st, ab;
    logic [1:0]  m;
    logic [31:0] f;
    n = 0;
    while (m_phase != P_IDLE) begin
      if (n >= 2000) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s timeout: job still active after %0d cycles, required idle", cur_test, n);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'b00, 32'd0, 1'b0, 1'b0);
        break;
      end
      case (kind)
        1:       begin rr = 1'b1; wr = (m_rc == m_words); end
        2:       begin rr = 1'b1; wr = 1'b1; end
        default: begin rr = ($urandom_range(99) < 60); wr = ($urandom_range(99) < 50); end
      endcase
      st = 1'b0; ab = 1'b0; m = ms; f = fs;
      if (noisy) begin
        st = ($urandom_range(7) == 0);
        m  = 2'($urandom_range(3));
        f  = $urandom_range(200);
        ab = ($urandom_range(79) == 0);
      end
      applyStimulus(1'b1, st, ab, m, f, rr, wr);
      n++;
    end
  endtask

  task automatic run_job(input string name, input logic [1:0] ms,
                         input logic [31:0] fs, input int kind, input bit noisy);
    bit ab;
    cur_test = name;
    ab = noisy && ($urandom_range(15) == 0);
    applyStimulus(1'b1, 1'b1, ab, ms, fs, 1'b0, 1'b0);
    drain_job(ms, fs, kind, noisy);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode_sel = 2'b00;
    filesize = 32'd0; rd_req = 1'b0; wr_req = 1'b0;

    cur_test = "reset";
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 1'b0, 1'b0);
    idle(2);

    run_job("fir16", 2'b10, 32'd16, 1, 1'b0);
    idle(2);
    run_job("fft64", 2'b01, 32'd64, 2, 1'b0);
    idle(2);

    // Writes requested with nothing read yet must not be granted.
    cur_test = "iir_gate";
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 32'd8, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 32'd8, 1'b0, 1'b1);
    drain_job(2'b11, 32'd8, 2, 1'b0);
    idle(2);

    run_job("fs0", 2'b01, 32'd0, 2, 1'b0);
    idle(2);
    run_job("fs3", 2'b01, 32'd3, 2, 1'b0);
    idle(2);

    // Abort once two of eight words have been read, then run a fresh job.
    cur_test = "abort";
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, 32'd32, 1'b0, 1'b0);
    n = 0;
    while (m_rc < 2 && n < 50) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 32'd32, 1'b1, 1'b0);
      n++;
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b11, 32'd32, 1'b1, 1'b0);
    idle(2);
    run_job("fir_after_abort", 2'b10, 32'd16, 1, 1'b0);
    idle(2);

    // Reset in the middle of a job, then an illegal-mode start.
    cur_test = "reset_mid";
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 32'd40, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 2'b01, 32'd40, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 2'b01, 32'd40, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 32'd20, 1'b1, 1'b1);
    idle(3);

    // Abort and start together: abort wins.
    cur_test = "abort_start";
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 32'd16, 1'b0, 1'b0);
    idle(2);

    for (int j = 0; j < 40; j++) begin
      run_job("random", 2'($urandom_range(3)), $urandom_range(100), 0, 1'b1);
      idle($urandom_range(2));
    end

    cur_test = "final";
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    checks++;
    if (done_seen != m_dones) begin
      errors++;
      $display("[TB] FAIL done_pulses: got %0d, required %0d", done_seen, m_dones);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
